// File: rtl/cpu_datapath_pkg.sv
// Shared types for the execution datapath: word, register address, ALU op.
// Also provides a printable symbol per ALU op for traces.
package cpu_datapath_pkg;

    typedef logic [31:0] Word;
    typedef logic [4:0]  RegAddress;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SHL  = 4'd5,
        SHR  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } AluOp;

    localparam int unsigned NumRegs = 32;

    function automatic string AluOp_symbol(AluOp op);
        case (op)
            ADD:     return "+";
            SUB:     return "-";
            AND:     return "&";
            OR:      return "|";
            XOR:     return "^";
            SHL:     return "<<";
            SHR:     return ">>";
            SRA:     return ">>>";
            SLT:     return "<";
            SLTU:    return "<u";
            default: return "?";
        endcase
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: y = a <op> b, modulo 2^32, no flags.
// Unassigned op codes (10..15) yield zero.
module alu
    import cpu_datapath_pkg::*;
(
    input  AluOp op,
    input  Word  a,
    input  Word  b,
    output Word  y
);

    // Select the result for the requested operation
    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            SHL:     y = a << b[4:0];
            SHR:     y = a >> b[4:0];
            SRA:     y = Word'($signed(a) >>> b[4:0]);
            SLT:     y = {31'b0, $signed(a) < $signed(b)};
            SLTU:    y = {31'b0, a < b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-cycle datapath: 32x32 register file feeding an ALU, result written back.
// Optional macro REGFILE_DUMP_EN adds a simulation-only dump task.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      write_enable,
    input  AluOp      op,
    input  RegAddress dst,
    input  RegAddress src1,
    input  Word       val2,
    input  RegAddress src2,
    output Word       out,
    output Word       rdata2
);

    Word  regs_q [NumRegs];
    Word  a;
    logic wr_d;

    // r0 always reads as zero regardless of array contents
    assign a      = (src1 == '0) ? '0 : regs_q[src1];
    assign rdata2 = (src2 == '0) ? '0 : regs_q[src2];

    // Writes to r0 are dropped so it stays hardwired
    assign wr_d = write_enable && (dst != '0);

    alu u_alu (
        .op (op),
        .a  (a),
        .b  (val2),
        .y  (out)
    );

    // Reset clears every register and overrides any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_d) begin
            regs_q[dst] <= out;
        end
    end

`ifdef REGFILE_DUMP_EN
    task automatic dump();
        for (int i = 0; i < NumRegs; i++) begin
            $display("r%0d = %0d", i, (i == 0) ? 32'd0 : regs_q[i]);
        end
    endtask
`else
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: vector table plus register sweeps,
// with expected outputs queued at drive time and compared after settling.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      write_enable;
    AluOp      op;
    RegAddress dst;
    RegAddress src1;
    Word       val2;
    RegAddress src2;
    Word       out;
    Word       rdata2;

    cpu_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .op           (op),
        .dst          (dst),
        .src1         (src1),
        .val2         (val2),
        .src2         (src2),
        .out          (out),
        .rdata2       (rdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  op;
        logic [4:0]  dst;
        logic [4:0]  src1;
        logic [31:0] val2;
        logic [4:0]  src2;
        logic [31:0] exp_out;
        logic [31:0] exp_rd2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_out;
        logic [31:0] exp_rd2;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check_one();
        sb_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=0 entries want=1");
            return;
        end
        e = sb.pop_front();
        total++;
        if (out !== e.exp_out) begin
            bad++;
            $display("FAIL %s out got=%h want=%h", e.name, out, e.exp_out);
        end
        total++;
        if (rdata2 !== e.exp_rd2) begin
            bad++;
            $display("FAIL %s rdata2 got=%h want=%h", e.name, rdata2, e.exp_rd2);
        end
    endtask

    // Drive one cycle just after the edge, check before the next edge
    task automatic step(input vec_t v, input string nm);
        sb_t e;
        reset        = v.rst;
        write_enable = v.we;
        op           = AluOp'(v.op);
        dst          = v.dst;
        src1         = v.src1;
        val2         = v.val2;
        src2         = v.src2;
        e.name       = nm;
        e.exp_out    = v.exp_out;
        e.exp_rd2    = v.exp_rd2;
        sb.push_back(e);
        #3;
        check_one();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic rs, logic w, logic [3:0] o,
                                logic [4:0] d, logic [4:0] s1,
                                logic [31:0] v2, logic [4:0] s2,
                                logic [31:0] eo, logic [31:0] er);
        vec_t v;
        v.rst = rs; v.we = w; v.op = o; v.dst = d; v.src1 = s1;
        v.val2 = v2; v.src2 = s2; v.exp_out = eo; v.exp_rd2 = er;
        return v;
    endfunction

    vec_t        tbl[$];
    logic [31:0] exp_regs[32];

    initial begin
        reset = 1'b1; write_enable = 1'b0; op = ADD;
        dst = '0; src1 = '0; val2 = '0; src2 = '0;
        @(posedge clk);
        #1;

        // reset held: registers zero, out = alu(op, 0, val2)
        tbl.push_back(mk(1, 1, 0, 3, 3, 32'd7, 5, 32'd7, 32'd0));
        // program sequence
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'd10, 1, 32'd10, 32'd0));
        tbl.push_back(mk(0, 1, 5, 1, 1, 32'd3, 1, 32'd80, 32'd10));
        tbl.push_back(mk(0, 1, 1, 2, 1, 32'd20, 1, 32'd60, 32'd80));
        tbl.push_back(mk(0, 1, 0, 3, 2, 32'd1, 2, 32'd61, 32'd60));
        tbl.push_back(mk(0, 1, 0, 4, 3, 32'd1, 3, 32'd62, 32'd61));
        tbl.push_back(mk(0, 1, 0, 5, 4, 32'd1, 4, 32'd63, 32'd62));
        // write to r0 discarded
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'd5, 5, 32'd5, 32'd63));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'd0, 0, 32'd0, 32'd0));
        // op sweep with r1 = 0x80000000
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'd80));
        tbl.push_back(mk(0, 0, 0, 9, 1, 32'd1, 1, 32'h8000_0001, 32'h8000_0000));
        tbl.push_back(mk(0, 0, 1, 9, 1, 32'd1, 0, 32'h7FFF_FFFF, 32'd0));
        tbl.push_back(mk(0, 0, 6, 9, 1, 32'd1, 0, 32'h4000_0000, 32'd0));
        tbl.push_back(mk(0, 0, 7, 9, 1, 32'd1, 0, 32'hC000_0000, 32'd0));
        tbl.push_back(mk(0, 0, 8, 9, 1, 32'd1, 0, 32'd1, 32'd0));
        tbl.push_back(mk(0, 0, 9, 9, 1, 32'd1, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 5, 9, 1, 32'd33, 0, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 2, 9, 1, 32'h8000_000F, 0, 32'h8000_0000, 32'd0));
        tbl.push_back(mk(0, 0, 3, 9, 1, 32'd1, 0, 32'h8000_0001, 32'd0));
        tbl.push_back(mk(0, 0, 4, 9, 1, 32'hFFFF_FFFF, 0, 32'h7FFF_FFFF, 32'd0));
        tbl.push_back(mk(0, 1, 10, 9, 1, 32'd1, 9, 32'd0, 32'd0));
        tbl.push_back(mk(0, 0, 15, 9, 1, 32'd1, 9, 32'd0, 32'd0));
        // write_enable low still drives out
        tbl.push_back(mk(0, 0, 0, 3, 0, 32'd9, 3, 32'd9, 32'd61));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'd0, 3, 32'd0, 32'd61));
        // same-cycle hazard on r4
        tbl.push_back(mk(0, 1, 0, 4, 0, 32'd5, 4, 32'd5, 32'd62));
        tbl.push_back(mk(0, 1, 0, 4, 4, 32'd1, 4, 32'd6, 32'd5));
        tbl.push_back(mk(0, 1, 0, 4, 4, 32'd1, 4, 32'd7, 32'd6));
        tbl.push_back(mk(0, 1, 0, 4, 4, 32'd1, 4, 32'd8, 32'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'd0, 4, 32'd0, 32'd8));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // full register readback: only r1..r5 nonzero
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        exp_regs[1] = 32'h8000_0000;
        exp_regs[2] = 32'd60;
        exp_regs[3] = 32'd61;
        exp_regs[4] = 32'd8;
        exp_regs[5] = 32'd63;
        for (int i = 0; i < 32; i++) begin
            step(mk(0, 0, 0, 0, 0, 32'd0, 5'(i), 32'd0, exp_regs[i]),
                 $sformatf("regs_r%0d", i));
        end
`ifdef REGFILE_DUMP_EN
        dut.dump();
`endif

        // reset beats a same-edge write
        step(mk(0, 1, 0, 7, 0, 32'hDEAD_BEEF, 7, 32'hDEAD_BEEF, 32'd0), "load_r7");
        step(mk(1, 1, 0, 8, 0, 32'h1234, 7, 32'h1234, 32'hDEAD_BEEF), "rst_wr_r8");
        step(mk(0, 0, 0, 0, 7, 32'd0, 8, 32'd0, 32'd0), "post_rst_r7_r8");
        for (int i = 0; i < 32; i++) begin
            step(mk(0, 0, 0, 0, 5'(i), 32'd3, 5'(i), 32'd3, 32'd0),
                 $sformatf("post_rst_r%0d", i));
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
